// File: rtl/coin_acceptor.sv
// Coin-chute front end: synchronises and debounces the optical sensor, times how long
// the beam stays blocked, and turns that length into one coin pulse, a reject, or a jam.
module coin_acceptor #(
  parameter int DB_LEN      = 3,
  parameter int DIME_MIN    = 4,
  parameter int NICKEL_MIN  = 8,
  parameter int QUARTER_MIN = 16,
  parameter int QUARTER_MAX = 31,
  parameter int JAM_LEN     = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sense,
  input  logic accept_en,
  output logic nickel_in,
  output logic dime_in,
  output logic quarter_in,
  output logic reject,
  output logic jam,
  output logic busy
);

  typedef enum logic [2:0] {
    CLEAR,
    IDLE,
    MEASURE,
    CLASSIFY,
    JAMMED
  } state_t;

  localparam logic [3:0] DB_TOP      = 4'(DB_LEN - 1);
  localparam logic [6:0] DIME_L      = 7'(DIME_MIN);
  localparam logic [6:0] NICKEL_L    = 7'(NICKEL_MIN);
  localparam logic [6:0] QUARTER_L   = 7'(QUARTER_MIN);
  localparam logic [6:0] QUARTER_H   = 7'(QUARTER_MAX);
  localparam logic [6:0] JAM_L       = 7'(JAM_LEN);

  logic [1:0] sync_reg;
  logic       db_reg;
  logic       db_prev_reg;
  logic [3:0] db_cnt_reg;
  logic       db_rise;

  state_t     state_reg;
  logic [6:0] len_reg;
  logic       nickel_reg;
  logic       dime_reg;
  logic       quarter_reg;
  logic       reject_reg;
  logic       jam_reg;
  logic       busy_reg;

  logic       is_dime;
  logic       is_nickel;
  logic       is_quarter;

  // Reset parks the chute as "blocked" so a coin present at release is never measured.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_reg <= 2'b11;
    end else begin
      sync_reg <= {sync_reg[0], sense};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      db_reg      <= 1'b1;
      db_prev_reg <= 1'b1;
      db_cnt_reg  <= 4'd0;
    end else begin
      db_prev_reg <= db_reg;
      if (sync_reg[1] != db_reg) begin
        if (db_cnt_reg == DB_TOP) begin
          db_reg     <= sync_reg[1];
          db_cnt_reg <= 4'd0;
        end else begin
          db_cnt_reg <= db_cnt_reg + 4'd1;
        end
      end else begin
        db_cnt_reg <= 4'd0;
      end
    end
  end

  assign db_rise = db_reg & ~db_prev_reg;

  assign is_dime    = (len_reg >= DIME_L)    && (len_reg < NICKEL_L);
  assign is_nickel  = (len_reg >= NICKEL_L)  && (len_reg < QUARTER_L);
  assign is_quarter = (len_reg >= QUARTER_L) && (len_reg <= QUARTER_H);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= CLEAR;
      len_reg     <= 7'd0;
      nickel_reg  <= 1'b0;
      dime_reg    <= 1'b0;
      quarter_reg <= 1'b0;
      reject_reg  <= 1'b0;
      jam_reg     <= 1'b0;
      busy_reg    <= 1'b1;
    end else begin
      nickel_reg  <= 1'b0;
      dime_reg    <= 1'b0;
      quarter_reg <= 1'b0;
      reject_reg  <= 1'b0;
      case (state_reg)
        CLEAR: begin
          if (!db_reg) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        end
        IDLE: begin
          if (db_rise) begin
            state_reg <= MEASURE;
            len_reg   <= 7'd1;
            busy_reg  <= 1'b1;
          end
        end
        MEASURE: begin
          if (!db_reg) begin
            state_reg <= CLASSIFY;
          end else begin
            len_reg <= len_reg + 7'd1;
            if (len_reg + 7'd1 == JAM_L) begin
              state_reg <= JAMMED;
              jam_reg   <= 1'b1;
            end
          end
        end
        CLASSIFY: begin
          // accept_en is only looked at here; earlier changes during the coin are ignored.
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          if (!accept_en) begin
            reject_reg <= 1'b1;
          end else if (is_dime) begin
            dime_reg <= 1'b1;
          end else if (is_nickel) begin
            nickel_reg <= 1'b1;
          end else if (is_quarter) begin
            quarter_reg <= 1'b1;
          end else begin
            reject_reg <= 1'b1;
          end
        end
        JAMMED: begin
          if (!db_reg) begin
            state_reg  <= IDLE;
            jam_reg    <= 1'b0;
            reject_reg <= 1'b1;
            busy_reg   <= 1'b0;
          end
        end
        default: begin
          state_reg <= CLEAR;
          busy_reg  <= 1'b1;
        end
      endcase
    end
  end

  assign nickel_in  = nickel_reg;
  assign dime_in    = dime_reg;
  assign quarter_in = quarter_reg;
  assign reject     = reject_reg;
  assign jam        = jam_reg;
  assign busy       = busy_reg;

endmodule

// File: doc/coin_acceptor.md
COIN_ACCEPTOR -- requirements
Module: coin_acceptor

Interface
REQ-001 Parameter DB_LEN, default 3: debounce length in cycles, 1..15.
REQ-002 Parameter DIME_MIN, default 4: minimum blocked length classified as dime.
REQ-003 Parameter NICKEL_MIN, default 8: minimum blocked length classified as nickel; dime window is DIME_MIN..NICKEL_MIN-1.
REQ-004 Parameter QUARTER_MIN, default 16: minimum blocked length classified as quarter; nickel window is NICKEL_MIN..QUARTER_MIN-1.
REQ-005 Parameter QUARTER_MAX, default 31: maximum blocked length classified as quarter.
REQ-006 Parameter JAM_LEN, default 64: blocked length at which a jam is declared; must be less than 128.
REQ-007 CLK  input  1  system clock; all state updates on rising edge.
REQ-008 RST_N  input  1  synchronous, active-low reset.
REQ-009 SENSE  input  1  raw coin-chute optical sensor; high = beam blocked; asynchronous, may bounce.
REQ-010 ACCEPT_EN  input  1  high = downstream drink machine accepts coins; low = every coin is rejected.
REQ-011 NICKEL_IN  output  1  one-cycle pulse, nickel accepted; feeds drink machine NICKEL_IN.
REQ-012 DIME_IN  output  1  one-cycle pulse, dime accepted.
REQ-013 QUARTER_IN  output  1  one-cycle pulse, quarter accepted.
REQ-014 REJECT  output  1  one-cycle pulse, coin routed to return slot.
REQ-015 JAM  output  1  level, chute blocked for JAM_LEN or more cycles.
REQ-016 BUSY  output  1  level, high in any state other than IDLE.

Function
REQ-017 SENSE SHALL pass through a 2-flop synchronizer before any other use.
REQ-018 Debounced level SHALL change only after the synchronized value differs from it for DB_LEN consecutive cycles; a shorter glitch SHALL leave it unchanged.
REQ-019 A clean SENSE pulse of W cycles SHALL produce a debounced high of exactly W cycles; blocked length L SHALL equal W.
REQ-020 FSM states SHALL be CLEAR, IDLE, MEASURE, CLASSIFY and JAMMED.
REQ-021 CLEAR SHALL go to IDLE on the first cycle the debounced level is low.
REQ-022 IDLE SHALL go to MEASURE on a debounced rising edge, loading the 7-bit length counter with 1.
REQ-023 MEASURE SHALL increment the counter each cycle the debounced level stays high.
REQ-024 MEASURE SHALL go to JAMMED when the counter reaches JAM_LEN, or to CLASSIFY on a debounced falling edge.
REQ-025 CLASSIFY SHALL last exactly one cycle, then go to IDLE.
REQ-026 CLASSIFY SHALL sample ACCEPT_EN and register exactly one output pulse, visible the following cycle: DIME_IN if L is DIME_MIN..NICKEL_MIN-1; NICKEL_IN if NICKEL_MIN..QUARTER_MIN-1; QUARTER_IN if QUARTER_MIN..QUARTER_MAX.
REQ-027 CLASSIFY SHALL pulse REJECT instead if L is outside all windows or ACCEPT_EN is low.
REQ-028 At most one of NICKEL_IN, DIME_IN, QUARTER_IN, REJECT SHALL be high in any cycle, and each SHALL be high for exactly one cycle per coin.
REQ-029 Latency from the first CLK edge sampling SENSE low after a clean pulse to the output pulse SHALL be DB_LEN+3 cycles.
REQ-030 JAMMED SHALL hold JAM high and suppress all pulses until the debounced level goes low.
REQ-031 On leaving JAMMED, the block SHALL pulse REJECT once, drop JAM in the same cycle, and go to IDLE.
REQ-032 ACCEPT_EN changes during MEASURE SHALL have no effect; only the CLASSIFY-cycle sample counts.
REQ-033 A new debounced rising edge SHALL not start a measurement until the FSM is back in IDLE.

Reset
REQ-034 While RST_N is low at a rising edge: FSM to CLEAR; both synchronizer flops and the debounced level to 1; counter to 0; NICKEL_IN, DIME_IN, QUARTER_IN, REJECT and JAM to 0; BUSY to 1.
REQ-035 A coin already in the chute at reset release SHALL be ignored (held in CLEAR) and SHALL produce no pulse.
REQ-036 Reset asserted mid-measurement or while JAMMED SHALL abort without any pulse.

Verification
REQ-037 Reset with SENSE=0, then release -> BUSY falls DB_LEN+3 cycles after release; all pulses and JAM stay 0.
REQ-038 ACCEPT_EN=1, clean SENSE pulses of 5, 10 and 20 cycles -> one DIME_IN, one NICKEL_IN and one QUARTER_IN respectively, each DB_LEN+3 cycles after SENSE falls.
REQ-039 ACCEPT_EN=1, pulses of 3 and 40 cycles -> REJECT only; 2-cycle glitch (less than DB_LEN) -> no output, BUSY stays 0.
REQ-040 SENSE 10-cycle pulse, ACCEPT_EN dropped to 0 during the coin -> REJECT, no NICKEL_IN.
REQ-041 SENSE held high 100 cycles -> JAM rises at L=64, no pulses; after SENSE falls, one REJECT pulse with JAM falling in the same cycle.
REQ-042 SENSE high with RST_N low, released mid-coin -> no pulse; the next clean 10-cycle coin -> NICKEL_IN.
